// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial front end for the one-bit input of the sequence detector.
// WIDTH-bit words arrive over a valid/ready handshake. Each word is shifted out
// one bit per BIT_CYCLES clocks on `s`, qualified by `s_valid`. Consecutive
// words stream with no idle gap, so the detector sees a continuous bit stream
// across word boundaries.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   in_data    word to serialize, sampled only on an accept
//   in_valid   upstream has a word on in_data
//   in_ready   block can accept a word this cycle
//   s          serial bit to the detector (0 when idle; gate on s_valid)
//   s_valid    s carries a real data bit this cycle
//   word_done  one-cycle pulse on the final cycle of a word's last bit
//   busy       high while shifting a word
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
    parameter int WIDTH      = 8,   // 2..32
    parameter int MSB_FIRST  = 1,   // 1 = MSB first, 0 = LSB first
    parameter int BIT_CYCLES = 1    // 1..16 clocks per bit
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             s,
    output logic             s_valid,
    output logic             word_done,
    output logic             busy
);

    // Counter widths, never narrower than one bit.
    localparam int BW = (WIDTH > 1)      ? $clog2(WIDTH)      : 1;
    localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sreg_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [DW-1:0]    div_cnt_reg;

    logic             div_last;
    logic             bit_last;
    logic             last;
    logic             accept;
    logic             cur_bit;
    logic [WIDTH-1:0] sreg_adv;

    // Terminal decodes come from registered counters only, so in_ready and
    // word_done have no path from any input.
    assign div_last = (div_cnt_reg == DIV_LAST);
    assign bit_last = (bit_cnt_reg == BIT_LAST);
    assign last     = (state_reg == SHIFT) && bit_last && div_last;
    assign accept   = in_valid && in_ready;

    // Bit order: pick the outgoing bit and the shift direction.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign cur_bit  = sreg_reg[WIDTH-1];
            assign sreg_adv = {sreg_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign cur_bit  = sreg_reg[0];
            assign sreg_adv = {1'b0, sreg_reg[WIDTH-1:1]};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // An accept in the last cycle keeps SHIFT with no bubble.
                if (last && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        s         = 1'b0;
        s_valid   = 1'b0;
        busy      = 1'b0;
        word_done = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                s         = cur_bit;
                s_valid   = 1'b1;
                busy      = 1'b1;
                word_done = last;
                in_ready  = last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Shift register and bit/divider counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_reg    <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else if (accept) begin
            sreg_reg    <= in_data;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else if (state_reg == SHIFT) begin
            if (div_last) begin
                div_cnt_reg <= '0;
                if (bit_last) begin
                    // Word finished with nothing queued: park cleared.
                    sreg_reg    <= '0;
                    bit_cnt_reg <= '0;
                end else begin
                    sreg_reg    <= sreg_adv;
                    bit_cnt_reg <= bit_cnt_reg + BW'(1);
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for serial_bit_feeder. Two instances run side by side:
//   cfg0: WIDTH=8, MSB_FIRST=1, BIT_CYCLES=1
//   cfg1: WIDTH=8, MSB_FIRST=0, BIT_CYCLES=3
// Each driver pushes the expected per-cycle bit stream of every accepted word
// into a queue; a separate monitor pops one entry per valid output cycle.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

    localparam int W = 8;

    typedef struct packed {
        logic b;   // expected s
        logic d;   // expected word_done
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input int cfg,
                         input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cfg%0d t=%0t got=%0h expected=%0h",
                     name, cfg, $time, got, want);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cfg
            localparam int MF = (gi == 0) ? 1 : 0;
            localparam int BC = (gi == 0) ? 1 : 3;

            logic         rst;
            logic [W-1:0] in_data;
            logic         in_valid;
            logic         in_ready;
            logic         s;
            logic         s_valid;
            logic         word_done;
            logic         busy;
            exp_t         expq[$];
            int           words_out = 0;

            serial_bit_feeder #(
                .WIDTH     (W),
                .MSB_FIRST (MF),
                .BIT_CYCLES(BC)
            ) dut (
                .clk      (clk),
                .rst      (rst),
                .in_data  (in_data),
                .in_valid (in_valid),
                .in_ready (in_ready),
                .s        (s),
                .s_valid  (s_valid),
                .word_done(word_done),
                .busy     (busy)
            );

            // Reference: bit k of the stream is data[W-1-k] (MSB first) or
            // data[k] (LSB first), each repeated BC cycles; done on the very
            // last cycle of the word.
            task automatic push_word(input logic [W-1:0] data);
                exp_t e;
                for (int k = 0; k < W; k++) begin
                    for (int c = 0; c < BC; c++) begin
                        e.b = (MF != 0) ? data[W-1-k] : data[k];
                        e.d = (k == W - 1) && (c == BC - 1);
                        expq.push_back(e);
                    end
                end
            endtask

            // One handshake attempt: drive at negedge, decide acceptance just
            // before the edge (in_ready depends only on registered state).
            task automatic drive_cycle(input logic v, input logic [W-1:0] d,
                                       output logic acc);
                @(negedge clk);
                in_valid = v;
                in_data  = d;
                #1;
                acc = in_valid && in_ready;
                @(posedge clk);
                if (acc) push_word(d);
            endtask

            task automatic send_word(input logic [W-1:0] d);
                logic acc;
                acc = 1'b0;
                for (int c = 0; c < 100 && !acc; c++) drive_cycle(1'b1, d, acc);
                check("accept_timeout", gi, acc, 1);
            endtask

            task automatic check_reset_outputs();
                check("rst_s",         gi, s,         0);
                check("rst_s_valid",   gi, s_valid,   0);
                check("rst_word_done", gi, word_done, 0);
                check("rst_busy",      gi, busy,      0);
                check("rst_in_ready",  gi, in_ready,  1);
            endtask

            initial begin : driver
                logic acc;
                logic [W-1:0] w0;
                logic [W-1:0] w1;
                int waited;
                rst      = 1'b0;
                in_valid = 1'b0;
                in_data  = '0;
                #2 rst = 1'b1;
                #1 check_reset_outputs();
                repeat (2) @(negedge clk);
                #2 rst = 1'b0;

                // Directed words, valid held high -> back-to-back stream.
                w0 = (gi == 0) ? 8'hD0 : 8'h0B;
                w1 = (gi == 0) ? 8'h0D : 8'hB0;
                send_word(w0);
                send_word(w1);
                @(negedge clk);
                in_valid = 1'b0;

                // Backpressure: offer words with changing data mid-word.
                for (int i = 0; i < 40; i++) begin
                    drive_cycle($urandom_range(0, 1) == 1, W'($urandom), acc);
                end

                // Reset mid-word.
                send_word(W'($urandom));
                repeat (3) @(negedge clk);
                in_valid = 1'b0;
                check("busy_before_rst", gi, busy, 1);
                #3 rst = 1'b1;
                expq.delete();
                #1 check_reset_outputs();
                @(negedge clk);
                #2 rst = 1'b0;

                // Randomised traffic.
                for (int i = 0; i < 300; i++) begin
                    drive_cycle($urandom_range(0, 2) != 0, W'($urandom), acc);
                end

                // Drain.
                @(negedge clk);
                in_valid = 1'b0;
                waited = 0;
                while ((expq.size() != 0 || busy) && waited < 200) begin
                    @(negedge clk);
                    waited++;
                end
                check("drain_left", gi, expq.size(), 0);
                done_cnt++;
            end

            // Monitor: one expected entry per valid output cycle, no gaps.
            always @(negedge clk) begin
                exp_t e;
                if (!rst) begin
                    check("valid_vs_model", gi, s_valid, expq.size() != 0);
                    check("busy", gi, busy, s_valid);
                    if (s_valid && expq.size() != 0) begin
                        e = expq.pop_front();
                        check("s", gi, s, e.b);
                        check("word_done", gi, word_done, e.d);
                        check("in_ready_busy", gi, in_ready, e.d);
                        if (e.d) begin
                            words_out++;
                            $display("cfg%0d word %0d done t=%0t", gi, words_out, $time);
                        end
                    end else if (!s_valid) begin
                        check("idle_s", gi, s, 0);
                        check("idle_word_done", gi, word_done, 0);
                        check("idle_in_ready", gi, in_ready, 1);
                    end
                end
            end
        end
    endgenerate

    initial begin : supervisor
        for (int c = 0; c < 20000 && done_cnt < 2; c++) @(posedge clk);
        check("completion", 0, done_cnt, 2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
